bf16_range_encoder: RTL and testbench

BF16_RANGE_ENCODER -- requirements
Module: bf16_range_encoder

---
 rtl/bf16_range_encoder.sv | 123 ++++++++++++
 tb/tb_bf16_range_encoder.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf16_range_encoder.sv
// Two-stage encoder from a range index (0..31) to the bfloat16 lower bound index/8,
// with a built-in sweep of all indices. Define BF16_RANGE_ENCODER_UPPER_EN to add output_upper_x.
module bf16_range_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  input_index,
  input  logic        input_valid,
  output logic        input_ready,
  input  logic        sweep_start,
  output logic        sweep_busy,
  output logic [15:0] output_x,
  output logic [4:0]  output_index,
  output logic        output_valid,
`ifdef BF16_RANGE_ENCODER_UPPER_EN
  output logic [15:0] output_upper_x,
`endif
  input  logic        output_ready
);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       inject;

  logic       vld_p1;
  logic [4:0] index_p1;
  logic [2:0] lead_p1;
`ifdef BF16_RANGE_ENCODER_UPPER_EN
  logic [2:0] lead_up_p1;
`endif

  logic       s1_ready, s2_ready, load_p1, adv_p2;
  logic [4:0] index_d;

  function automatic logic [2:0] lead_one(input logic [5:0] v);
    lead_one = 3'd0;
    for (int i = 0; i < 6; i++)
      if (v[i]) lead_one = 3'(i);
  endfunction

  // Bits below the leading one become the mantissa, left-aligned into 7 bits.
  function automatic logic [15:0] pack_bf16(input logic [5:0] v, input logic [2:0] p);
    logic [7:0] frac;
    frac = 8'(v) - (8'd1 << p);
    frac = frac << (3'd7 - p);
    if (v == 6'd0)
      pack_bf16 = 16'h0000;
    else
      pack_bf16 = {1'b0, 8'd124 + 8'(p), frac[6:0]};
  endfunction

  assign s2_ready    = !output_valid || output_ready;
  assign s1_ready    = !vld_p1 || s2_ready;
  assign adv_p2      = vld_p1 && s2_ready;
  assign sweep_busy  = (state_q == SWEEP);
  assign input_ready = !sweep_busy && s1_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inject  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sweep_start) begin
          state_d = SWEEP;
          cnt_d   = 5'd0;
        end
      end
      SWEEP: begin
        if (s1_ready) begin
          inject = 1'b1;
          if (cnt_q == 5'd31) state_d = IDLE;
          else                cnt_d   = cnt_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign load_p1 = inject || (input_valid && input_ready);
  assign index_d = inject ? cnt_q : input_index;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= 5'd0;
      vld_p1         <= 1'b0;
      output_valid   <= 1'b0;
      output_x       <= 16'h0000;
      output_index   <= 5'd0;
`ifdef BF16_RANGE_ENCODER_UPPER_EN
      output_upper_x <= 16'h0000;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_p1)     vld_p1 <= 1'b1;
      else if (adv_p2) vld_p1 <= 1'b0;
      // Stage 1 -> stage 2: pack the registered index into bfloat16
      if (s2_ready) output_valid <= vld_p1;
      if (adv_p2) begin
        output_x       <= pack_bf16({1'b0, index_p1}, lead_p1);
        output_index   <= index_p1;
`ifdef BF16_RANGE_ENCODER_UPPER_EN
        output_upper_x <= pack_bf16(6'(index_p1) + 6'd1, lead_up_p1);
`endif
      end
    end
  end

  // Input -> stage 1: index and leading-one position (data only, qualified by vld_p1)
  always_ff @(posedge clk) begin
    if (load_p1) begin
      index_p1   <= index_d;
      lead_p1    <= lead_one({1'b0, index_d});
`ifdef BF16_RANGE_ENCODER_UPPER_EN
      lead_up_p1 <= lead_one(6'(index_d) + 6'd1);
`endif
    end
  end

endmodule

// File: tb/tb_bf16_range_encoder.sv
// Randomized self-checking bench for bf16_range_encoder against a real-arithmetic model.
module tb_bf16_range_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  input_index;
  logic        input_valid;
  logic        input_ready;
  logic        sweep_start;
  logic        sweep_busy;
  logic [15:0] output_x;
  logic [4:0]  output_index;
  logic        output_valid;
  logic        output_ready;
`ifdef BF16_RANGE_ENCODER_UPPER_EN
  logic [15:0] output_upper_x;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;

  int          exp_q[$];
  int          got_idx[$];
  logic [15:0] got_x[$];
  logic [15:0] got_up[$];
  int          got_cyc[$];
  int          acc_cyc[$];

  bf16_range_encoder dut (
    .clk(clk), .rst_n(rst_n),
    .input_index(input_index), .input_valid(input_valid), .input_ready(input_ready),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy),
    .output_x(output_x), .output_index(output_index), .output_valid(output_valid),
`ifdef BF16_RANGE_ENCODER_UPPER_EN
    .output_upper_x(output_upper_x),
`endif
    .output_ready(output_ready)
  );

  always #5 clk = ~clk;

  // bfloat16 of v/8 taken from the IEEE double representation (v/8 is exact).
  function automatic logic [15:0] ref_bf16(int v);
    real r;
    logic [63:0] b;
    int e;
    if (v == 0) return 16'h0000;
    r = real'(v) / 8.0;
    b = $realtobits(r);
    e = int'(b[62:52]) - 1023 + 127;
    return {1'b0, e[7:0], b[51:45]};
  endfunction

  // Called at posedge+1 with inputs driven; records handshakes and advances one cycle.
  task automatic clk_step();
    #1;
    if (output_valid && output_ready) begin
      got_idx.push_back(int'(output_index));
      got_x.push_back(output_x);
`ifdef BF16_RANGE_ENCODER_UPPER_EN
      got_up.push_back(output_upper_x);
`endif
      got_cyc.push_back(cyc);
    end
    if (input_valid && input_ready) begin
      exp_q.push_back(int'(input_index));
      acc_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_q();
    exp_q.delete(); got_idx.delete(); got_x.delete(); got_up.delete();
    got_cyc.delete(); acc_cyc.delete();
  endtask

  task automatic idle_inputs();
    input_valid = 1'b0; input_index = 5'd0; sweep_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle_inputs(); output_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (output_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", output_valid); end
    total++; if (output_x !== 16'h0000) begin bad++; $display("FAIL reset_x got=%h want=0000", output_x); end
    total++; if (output_index !== 5'd0) begin bad++; $display("FAIL reset_index got=%0d want=0", output_index); end
    total++; if (sweep_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", sweep_busy); end
    rst_n = 1'b1;
    #1;
    total++; if (input_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", input_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    clear_q(); output_ready = 1'b1;
    input_valid = 1'b1; input_index = 5'd5;
    clk_step();
    idle_inputs();
    total++; if (output_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%b want=0", output_valid); end
    clk_step();
    total++;
    if (output_valid !== 1'b1 || output_x !== 16'h3F20 || output_index !== 5'd5) begin
      bad++; $display("FAIL single_5 got v=%b x=%h i=%0d want v=1 x=3F20 i=5", output_valid, output_x, output_index);
    end
    clk_step(); clk_step();
  endtask

  task automatic test_back_to_back();
    logic [15:0] want [4] = '{16'h0000, 16'h3E00, 16'h3E80, 16'h3EC0};
    clear_q(); output_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      input_valid = 1'b1; input_index = 5'(i);
      clk_step();
    end
    idle_inputs();
    repeat (4) clk_step();
    total++;
    if (got_x.size() != 4 || acc_cyc.size() != 4) begin
      bad++; $display("FAIL b2b_count got=%0d want=4", got_x.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (got_x[i] !== want[i] || got_idx[i] != i || got_cyc[i] != acc_cyc[0] + 2 + i) begin
          bad++; $display("FAIL b2b_%0d got x=%h i=%0d cyc=%0d want x=%h i=%0d cyc=%0d",
                          i, got_x[i], got_idx[i], got_cyc[i], want[i], i, acc_cyc[0] + 2 + i);
        end
      end
    end
  endtask

  task automatic test_known_values();
    int          idx  [7] = '{1, 2, 3, 4, 8, 16, 31};
    logic [15:0] want [7] = '{16'h3E00, 16'h3E80, 16'h3EC0, 16'h3F00, 16'h3F80, 16'h4000, 16'h4078};
    clear_q(); output_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      input_valid = 1'b1; input_index = 5'(idx[i]);
      clk_step();
    end
    idle_inputs();
    repeat (4) clk_step();
    total++;
    if (got_x.size() != 7) begin
      bad++; $display("FAIL known_count got=%0d want=7", got_x.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        total++;
        if (got_x[i] !== want[i] || got_idx[i] != idx[i]) begin
          bad++; $display("FAIL known_%0d got x=%h i=%0d want x=%h", idx[i], got_x[i], got_idx[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    clear_q(); output_ready = 1'b0;
    input_valid = 1'b1; input_index = 5'd8;  clk_step();
    input_index = 5'd16; clk_step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (output_valid !== 1'b1 || output_x !== 16'h3F80 || input_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold_%0d got v=%b x=%h rdy=%b want v=1 x=3F80 rdy=0", i, output_valid, output_x, input_ready);
      end
      clk_step();
    end
    output_ready = 1'b1;
    repeat (4) clk_step();
    total++;
    if (got_x.size() != 2) begin
      bad++; $display("FAIL bp_count got=%0d want=2", got_x.size());
    end else begin
      total++;
      if (got_x[0] !== 16'h3F80 || got_x[1] !== 16'h4000) begin
        bad++; $display("FAIL bp_order got %h,%h want 3F80,4000", got_x[0], got_x[1]);
      end
    end
  endtask

  task automatic test_random();
    logic stalled;
    logic [15:0] px;
    logic [4:0] pi;
    int n;
    clear_q();
    for (int c = 0; c < 400; c++) begin
      input_valid  = ($urandom_range(0, 3) != 0);
      input_index  = 5'($urandom_range(0, 31));
      output_ready = ($urandom_range(0, 3) != 0);
      #1;
      stalled = output_valid && !output_ready;
      px = output_x; pi = output_index;
      #0;
      clk_step_settled();
      if (stalled) begin
        total++;
        if (output_valid !== 1'b1 || output_x !== px || output_index !== pi) begin
          bad++; $display("FAIL rand_hold cyc=%0d got v=%b x=%h i=%0d want v=1 x=%h i=%0d", cyc, output_valid, output_x, output_index, px, pi);
        end
      end
    end
    idle_inputs(); output_ready = 1'b1;
    repeat (4) clk_step();
    total++;
    if (got_x.size() != exp_q.size()) begin
      bad++; $display("FAIL rand_count got=%0d want=%0d", got_x.size(), exp_q.size());
    end
    n = (got_x.size() < exp_q.size()) ? got_x.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      total++;
      if (got_idx[i] != exp_q[i] || got_x[i] !== ref_bf16(exp_q[i])
`ifdef BF16_RANGE_ENCODER_UPPER_EN
          || got_up[i] !== ref_bf16(exp_q[i] + 1)
`endif
         ) begin
        bad++; $display("FAIL rand_item_%0d got i=%0d x=%h want i=%0d x=%h", i, got_idx[i], got_x[i], exp_q[i], ref_bf16(exp_q[i]));
      end
    end
  endtask

  // Same as clk_step, entered 1 time unit later (settling already done by caller).
  task automatic clk_step_settled();
    if (output_valid && output_ready) begin
      got_idx.push_back(int'(output_index));
      got_x.push_back(output_x);
`ifdef BF16_RANGE_ENCODER_UPPER_EN
      got_up.push_back(output_upper_x);
`endif
      got_cyc.push_back(cyc);
    end
    if (input_valid && input_ready) begin
      exp_q.push_back(int'(input_index));
      acc_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_sweep();
    int want[$];
    int budget;
    clear_q(); output_ready = 1'b1;
    want.push_back(9);
    for (int i = 0; i < 32; i++) want.push_back(i);
    input_valid = 1'b1; input_index = 5'd9; sweep_start = 1'b1;
    clk_step();
    sweep_start = 1'b0;
    #1;
    total++;
    if (sweep_busy !== 1'b1 || input_ready !== 1'b0) begin
      bad++; $display("FAIL sweep_enter got busy=%b rdy=%b want busy=1 rdy=0", sweep_busy, input_ready);
    end
    budget = 0;
    while (sweep_busy === 1'b1 && budget < 300) begin
      input_valid  = ($urandom_range(0, 1) != 0);
      input_index  = 5'($urandom_range(0, 31));
      output_ready = ($urandom_range(0, 3) != 0);
      sweep_start  = (budget == 5);
      #1;
      if (input_ready !== 1'b0) begin
        total++; bad++; $display("FAIL sweep_in_ready got=%b want=0", input_ready);
      end
      clk_step_settled();
      budget++;
    end
    total++;
    if (sweep_busy !== 1'b0) begin
      bad++; $display("FAIL sweep_timeout got busy=%b want=0", sweep_busy);
    end
    idle_inputs(); output_ready = 1'b1;
    repeat (4) clk_step();
    total++;
    if (got_idx.size() != want.size()) begin
      bad++; $display("FAIL sweep_count got=%0d want=%0d", got_idx.size(), want.size());
    end else begin
      for (int i = 0; i < want.size(); i++) begin
        total++;
        if (got_idx[i] != want[i] || got_x[i] !== ref_bf16(want[i])) begin
          bad++; $display("FAIL sweep_item_%0d got i=%0d x=%h want i=%0d x=%h", i, got_idx[i], got_x[i], want[i], ref_bf16(want[i]));
        end
      end
      total++;
      if (got_x[want.size() - 1] !== 16'h4078) begin
        bad++; $display("FAIL sweep_last got=%h want=4078", got_x[want.size() - 1]);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    clear_q(); output_ready = 1'b0;
    sweep_start = 1'b1; clk_step();
    sweep_start = 1'b0;
    repeat (3) clk_step();
    total++;
    if (output_valid !== 1'b1 || sweep_busy !== 1'b1) begin
      bad++; $display("FAIL rst_pre got v=%b busy=%b want v=1 busy=1", output_valid, sweep_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (output_valid !== 1'b0 || sweep_busy !== 1'b0 || output_x !== 16'h0000) begin
      bad++; $display("FAIL rst_async got v=%b busy=%b x=%h want v=0 busy=0 x=0000", output_valid, sweep_busy, output_x);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; output_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      clk_step();
      total++;
      if (output_valid !== 1'b0 || sweep_busy !== 1'b0) begin
        bad++; $display("FAIL rst_stale_%0d got v=%b busy=%b want 0 0", i, output_valid, sweep_busy);
      end
    end
  endtask

`ifdef BF16_RANGE_ENCODER_UPPER_EN
  task automatic test_upper();
    clear_q(); output_ready = 1'b1;
    input_valid = 1'b1; input_index = 5'd31; clk_step();
    input_index = 5'd7; clk_step();
    input_index = 5'd0; clk_step();
    idle_inputs();
    repeat (4) clk_step();
    total++;
    if (got_x.size() != 3) begin
      bad++; $display("FAIL upper_count got=%0d want=3", got_x.size());
    end else begin
      total++;
      if (got_up[0] !== 16'h4080 || got_x[1] !== 16'h3F60 || got_up[1] !== 16'h3F80 || got_up[2] !== 16'h3E00) begin
        bad++; $display("FAIL upper_vals got %h %h/%h %h want 4080 3F60/3F80 3E00", got_up[0], got_x[1], got_up[1], got_up[2]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_known_values();
    test_backpressure();
    test_random();
    test_sweep();
`ifdef BF16_RANGE_ENCODER_UPPER_EN
    test_upper();
`endif
    test_reset_mid_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
